// File: rtl/du.sv
// Radix-2 restoring divide unit for RV32M DIV/DIVU/REM/REMU with start/busy/done handshake.
// Optional DU_EARLY_OUT_EN: finish in the fast path when |a| < |b|.
module du #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [1:0]      divctl,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] divres
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned RW = XLEN + 1;

    typedef enum logic [2:0] {IDLE, CALC, FIX, DONE, SPEC} state_t;

    state_t          state;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvsr;
    logic [XLEN-1:0] res;
    logic [RW-1:0]   rem;
    logic [CW-1:0]   cnt;
    logic            neg_q;
    logic            neg_r;
    logic            sel_rem;

    // Operand decode at accept time
    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div0;
    logic            ovf;
    logic            early;
    logic [XLEN-1:0] spec_res;

    assign is_signed = ~divctl[0];
    assign a_neg     = is_signed & a[XLEN-1];
    assign b_neg     = is_signed & b[XLEN-1];
    assign a_mag     = a_neg ? XLEN'(-a) : a;
    assign b_mag     = b_neg ? XLEN'(-b) : b;
    assign div0      = (b == '0);
    assign ovf       = is_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

`ifdef DU_EARLY_OUT_EN
    assign early = !div0 && !ovf && (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    // Fast-path result; early-out shares the divide-by-zero remainder (a itself)
    always_comb begin
        spec_res = '0;
        if (div0)
            spec_res = divctl[1] ? a : '1;
        else if (ovf)
            spec_res = divctl[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        else if (early)
            spec_res = divctl[1] ? a : '0;
    end

    // One restoring step: shift in next dividend bit, subtract if it fits
    logic [RW-1:0]   rem_sh;
    logic            fits;
    logic [RW-1:0]   rem_nx;
    logic [XLEN-1:0] quo_nx;

    assign rem_sh = RW'({rem, quo[XLEN-1]});
    assign fits   = (rem_sh >= {1'b0, dvsr});
    assign rem_nx = fits ? RW'(rem_sh - {1'b0, dvsr}) : rem_sh;
    assign quo_nx = {quo[XLEN-2:0], fits};

    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    assign q_fix = neg_q ? XLEN'(-quo) : quo;
    assign r_fix = neg_r ? XLEN'(-rem[XLEN-1:0]) : rem[XLEN-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            quo     <= '0;
            dvsr    <= '0;
            res     <= '0;
            rem     <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            sel_rem <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divres  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // busy stays high through the done cycle, so start there is dropped
                    if (start && !busy) begin
                        busy    <= 1'b1;
                        sel_rem <= divctl[1];
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        quo     <= a_mag;
                        dvsr    <= b_mag;
                        rem     <= '0;
                        cnt     <= '0;
                        if (div0 || ovf || early) begin
                            res   <= spec_res;
                            state <= SPEC;
                        end else begin
                            state <= CALC;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                CALC: begin
                    quo <= quo_nx;
                    rem <= rem_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(XLEN - 1))
                        state <= FIX;
                end
                FIX: begin
                    res   <= sel_rem ? r_fix : q_fix;
                    state <= DONE;
                end
                SPEC: state <= DONE;
                DONE: begin
                    done   <= 1'b1;
                    divres <= res;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_du.sv
// Self-checking bench for du: directed handshake/boundary steps plus random ops
// against an arithmetic reference model.
module tb_du;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  divctl;
    logic        busy;
    logic        done;
    logic [31:0] divres;

    int total = 0;
    int bad   = 0;

    du #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .divctl (divctl),
        .busy   (busy),
        .done   (done),
        .divres (divres)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_res(input logic [31:0] x, input logic [31:0] y,
                                            input logic [1:0] c);
        longint sx;
        longint sy;
        longint q;
        longint r;
        if (y == 32'd0)
            return c[1] ? x : 32'hFFFF_FFFF;
        if (!c[0]) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                return c[1] ? 32'd0 : 32'h8000_0000;
            sx = $signed(x);
            sy = $signed(y);
            q  = sx / sy;
            r  = sx % sy;
            return c[1] ? 32'(r) : 32'(q);
        end
        return c[1] ? (x % y) : (x / y);
    endfunction

    function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y,
                                   input logic [1:0] c);
        longint mx;
        longint my;
        if (y == 32'd0) return 2;
        if (!c[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
        mx = c[0] ? longint'(x) : longint'($signed(x));
        my = c[0] ? longint'(y) : longint'($signed(y));
        if (mx < 0) mx = -mx;
        if (my < 0) my = -my;
`ifdef DU_EARLY_OUT_EN
        if (mx < my) return 2;
`else
        if (mx < my) return 34;
`endif
        return 34;
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // n0 = edges already elapsed since the accept edge
    task automatic wait_done(input logic [31:0] exp, input int lat, input int n0,
                             input string tag);
        int n;
        bit seen;
        n    = n0;
        seen = 1'b0;
        while (n < 80 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        chk(32'(seen), 32'd1, {tag, "_done_seen"});
        chk(32'(n), 32'(lat), {tag, "_latency"});
        chk(divres, exp, {tag, "_result"});
        chk(32'(busy), 32'd1, {tag, "_busy_in_done"});
        @(posedge clk);
        #1;
        chk(32'(done), 32'd0, {tag, "_done_pulse"});
        chk(32'(busy), 32'd0, {tag, "_busy_after"});
    endtask

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] c,
                         input string tag);
        @(negedge clk);
        a      = x;
        b      = y;
        divctl = c;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk(32'(busy), 32'd1, {tag, "_accept"});
        wait_done(ref_res(x, y, c), ref_lat(x, y, c), 0, tag);
    endtask

    initial begin
        int cnt_done;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rc;

        // Reset held with start asserted
        rst_n  = 1'b0;
        start  = 1'b1;
        a      = 32'hFFFF_FFFD;
        b      = 32'hFFFF_FFFC;
        divctl = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk(32'(busy), 32'd0, "rst_busy");
        chk(32'(done), 32'd0, "rst_done");
        chk(divres, 32'd0, "rst_divres");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk(32'(busy), 32'd1, "rst_release_accept");
        wait_done(ref_res(32'hFFFF_FFFD, 32'hFFFF_FFFC, 2'b00),
                  ref_lat(32'hFFFF_FFFD, 32'hFFFF_FFFC, 2'b00), 0, "first_op");

        // Signed and unsigned sweeps, with hard constants alongside the model
        do_op(32'hFFFF_FFF9, 32'd2, 2'b00, "div_m7_2");
        chk(divres, 32'hFFFF_FFFD, "div_m7_2_const");
        do_op(32'hFFFF_FFF9, 32'd2, 2'b10, "rem_m7_2");
        chk(divres, 32'hFFFF_FFFF, "rem_m7_2_const");
        do_op(32'd7, 32'hFFFF_FFFE, 2'b00, "div_7_m2");
        chk(divres, 32'hFFFF_FFFD, "div_7_m2_const");
        do_op(32'd7, 32'hFFFF_FFFE, 2'b10, "rem_7_m2");
        chk(divres, 32'd1, "rem_7_m2_const");
        do_op(32'hFFFF_FFF9, 32'd2, 2'b01, "divu_big");
        chk(divres, 32'h7FFF_FFFC, "divu_big_const");
        do_op(32'hFFFF_FFF9, 32'd2, 2'b11, "remu_big");
        chk(divres, 32'd1, "remu_big_const");

        // Divide by zero, all four ops
        for (int i = 0; i < 4; i++) begin
            do_op(32'd5, 32'd0, 2'(i), $sformatf("dz%0d", i));
            chk(divres, (i >= 2) ? 32'd5 : 32'hFFFF_FFFF, $sformatf("dz%0d_const", i));
        end

        // Signed overflow and its unsigned counterpart
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b00, "ovf_div");
        chk(divres, 32'h8000_0000, "ovf_div_const");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b10, "ovf_rem");
        chk(divres, 32'd0, "ovf_rem_const");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b01, "ovf_divu");
        chk(divres, 32'd0, "ovf_divu_const");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b11, "ovf_remu");
        chk(divres, 32'h8000_0000, "ovf_remu_const");

        // Early-out candidate (full latency unless the option is built in)
        do_op(32'd3, 32'd10, 2'b00, "eo_div");
        chk(divres, 32'd0, "eo_div_const");
        do_op(32'd3, 32'd10, 2'b10, "eo_rem");
        chk(divres, 32'd3, "eo_rem_const");

        // Start pulse at edge 5 with new operands must be ignored
        @(negedge clk);
        a = 32'd100; b = 32'd7; divctl = 2'b00; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        a = 32'd9; b = 32'd3; divctl = 2'b10; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(32'd14, 34, 5, "busy_ignore");

        // Start held through the done cycle: ignored there, accepted one cycle later
        @(negedge clk);
        a = 32'd50; b = 32'd6; divctl = 2'b01; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        begin
            int n;
            bit seen;
            n = 0;
            seen = 1'b0;
            while (n < 80 && !seen) begin
                @(posedge clk);
                #1;
                n++;
                if (done === 1'b1) seen = 1'b1;
            end
            chk(32'(seen), 32'd1, "b2b_first_done");
            chk(divres, 32'd8, "b2b_first_result");
        end
        a = 32'd51; b = 32'd5; divctl = 2'b11; start = 1'b1;
        @(posedge clk);
        #1;
        chk(32'(busy), 32'd0, "b2b_done_cycle_ignored");
        @(posedge clk);
        #1;
        start = 1'b0;
        chk(32'(busy), 32'd1, "b2b_next_accept");
        wait_done(32'd1, 34, 0, "b2b_second");

        // Reset at edge 20 aborts the operation
        @(negedge clk);
        a = 32'd1000; b = 32'd3; divctl = 2'b00; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk(32'(busy), 32'd0, "abort_busy");
        @(negedge clk);
        rst_n = 1'b1;
        cnt_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) cnt_done++;
        end
        chk(32'(cnt_done), 32'd0, "abort_no_done");
        chk(divres, 32'd0, "abort_divres");

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'(-$urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) ra = 32'($urandom_range(0, 20));
            rc = 2'($urandom_range(0, 3));
            do_op(ra, rb, rc, $sformatf("rnd%0d_%h_%h_%0d", i, ra, rb, rc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
